// File: rtl/mips_seq_ctrl_if.sv
// Control inputs and strobe/status outputs of the MIPS multi-cycle sequencer.
// No valid/ready handshake: start is a level sampled only in IDLE, opcode only in DECODE.
interface mips_seq_ctrl_if;
    logic        start;
    logic [5:0]  opcode;
    logic        beq_eq;
    logic        ic_read;
    logic        ir_ld;
    logic        pc_incr;
    logic        pc_ld;
    logic        rf_read;
    logic        rf_write;
    logic        dc_read;
    logic        dc_write;
    logic        wb_sel;
    logic [3:0]  state;
    logic [15:0] retired;
    logic        halted;
    logic        illegal;

    modport slave (
        input  start, opcode, beq_eq,
        output ic_read, ir_ld, pc_incr, pc_ld, rf_read, rf_write,
               dc_read, dc_write, wb_sel, state, retired, halted, illegal
    );

    modport master (
        output start, opcode, beq_eq,
        input  ic_read, ir_ld, pc_incr, pc_ld, rf_read, rf_write,
               dc_read, dc_write, wb_sel, state, retired, halted, illegal
    );
endinterface

// File: rtl/mips_seq_ctrl.sv
// Multi-cycle MIPS control sequencer: fetch/decode/execute FSM with registered
// Moore strobes, a retired-instruction counter and a sticky illegal-opcode flag.
module mips_seq_ctrl #(
    parameter logic [5:0] LW_OP   = 6'd5,
    parameter logic [5:0] SW_OP   = 6'd6,
    parameter logic [5:0] BEQ_OP  = 6'd8,
    parameter logic [5:0] HALT_OP = 6'd63
) (
    input  logic           clk,
    input  logic           reset,
    mips_seq_ctrl_if.slave bus
);
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_IRLD   = 4'd2;
    localparam logic [3:0] S_DECODE = 4'd3;
    localparam logic [3:0] S_EXEC   = 4'd4;
    localparam logic [3:0] S_MEM    = 4'd5;
    localparam logic [3:0] S_WB     = 4'd6;
    localparam logic [3:0] S_BRANCH = 4'd7;
    localparam logic [3:0] S_HALT   = 4'd8;

    logic [3:0]  state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [15:0] retired_q, retired_d;
    logic        illegal_q, illegal_d;
    logic        op_is_alu;

    logic ic_read_q, irld_q, pc_ld_q, rf_read_q, rf_write_q;
    logic dc_read_q, dc_write_q, wb_sel_q, halted_q;
    logic ic_read_d, irld_d, pc_ld_d, rf_read_d, rf_write_d;
    logic dc_read_d, dc_write_d, wb_sel_d, halted_d;

    assign op_is_alu = (op_q == 6'd1) || (op_q == 6'd2) || (op_q == 6'd3) ||
                       (op_q == 6'd4) || (op_q == 6'd7);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        retired_d = retired_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_FETCH;
            S_FETCH:  state_d = S_IRLD;
            S_IRLD:   state_d = S_DECODE;
            S_DECODE: begin
                op_d    = bus.opcode;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op_q == LW_OP || op_q == SW_OP) begin
                    state_d = S_MEM;
                end else if (op_q == BEQ_OP) begin
                    state_d = S_BRANCH;
                end else if (op_q == HALT_OP) begin
                    state_d = S_HALT;
                end else if (op_is_alu) begin
                    state_d = S_WB;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_MEM: begin
                // A store completes here; a load still has its register write-back.
                if (op_q == SW_OP) begin
                    state_d   = S_FETCH;
                    retired_d = retired_q + 16'd1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB, S_BRANCH: begin
                state_d   = S_FETCH;
                retired_d = retired_q + 16'd1;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state and registered, so each output
    // comes straight off a flop and is aligned with the state it belongs to.
    always_comb begin
        ic_read_d  = (state_d == S_FETCH);
        irld_d     = (state_d == S_IRLD);
        rf_read_d  = (state_d == S_DECODE);
        pc_ld_d    = (state_d == S_BRANCH) && bus.beq_eq;
        dc_read_d  = (state_d == S_MEM) && (op_d == LW_OP);
        dc_write_d = (state_d == S_MEM) && (op_d == SW_OP);
        rf_write_d = (state_d == S_WB);
        wb_sel_d   = (state_d == S_WB) && (op_d == LW_OP);
        halted_d   = (state_d == S_HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= 6'd0;
            retired_q  <= 16'd0;
            illegal_q  <= 1'b0;
            ic_read_q  <= 1'b0;
            irld_q     <= 1'b0;
            pc_ld_q    <= 1'b0;
            rf_read_q  <= 1'b0;
            rf_write_q <= 1'b0;
            dc_read_q  <= 1'b0;
            dc_write_q <= 1'b0;
            wb_sel_q   <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            retired_q  <= retired_d;
            illegal_q  <= illegal_d;
            ic_read_q  <= ic_read_d;
            irld_q     <= irld_d;
            pc_ld_q    <= pc_ld_d;
            rf_read_q  <= rf_read_d;
            rf_write_q <= rf_write_d;
            dc_read_q  <= dc_read_d;
            dc_write_q <= dc_write_d;
            wb_sel_q   <= wb_sel_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.ic_read  = ic_read_q;
    assign bus.ir_ld    = irld_q;
    assign bus.pc_incr  = irld_q;
    assign bus.pc_ld    = pc_ld_q;
    assign bus.rf_read  = rf_read_q;
    assign bus.rf_write = rf_write_q;
    assign bus.dc_read  = dc_read_q;
    assign bus.dc_write = dc_write_q;
    assign bus.wb_sel   = wb_sel_q;
    assign bus.state    = state_q;
    assign bus.retired  = retired_q;
    assign bus.halted   = halted_q;
    assign bus.illegal  = illegal_q;
endmodule

// File: tb/tb_mips_seq_ctrl.sv
// Bench for mips_seq_ctrl: per-instruction expected cycle tables feed a queue
// that one compare process checks against the DUT on every falling clock edge.
module tb_mips_seq_ctrl;
  localparam logic [5:0] LW_OP   = 6'd5;
  localparam logic [5:0] SW_OP   = 6'd6;
  localparam logic [5:0] BEQ_OP  = 6'd8;
  localparam logic [5:0] HALT_OP = 6'd63;
  localparam int W = 31;

  localparam logic [10:0] F_IC  = 11'h400;
  localparam logic [10:0] F_IR  = 11'h200;
  localparam logic [10:0] F_PCI = 11'h100;
  localparam logic [10:0] F_PCL = 11'h080;
  localparam logic [10:0] F_RFR = 11'h040;
  localparam logic [10:0] F_RFW = 11'h020;
  localparam logic [10:0] F_DCR = 11'h010;
  localparam logic [10:0] F_DCW = 11'h008;
  localparam logic [10:0] F_WBS = 11'h004;
  localparam logic [10:0] F_HLT = 11'h002;
  localparam logic [10:0] F_ILL = 11'h001;

  logic clk;
  logic reset;
  mips_seq_ctrl_if bus();

  mips_seq_ctrl #(
    .LW_OP(LW_OP), .SW_OP(SW_OP), .BEQ_OP(BEQ_OP), .HALT_OP(HALT_OP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w, act_w;
  int n_chk;
  int n_err;
  logic [15:0] ret_m;
  logic ill_m;
  logic idle_m;
  logic [5:0] alu_ops [5];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t act=timeout exp=finish", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] w(input logic [3:0] st, input logic [10:0] fl);
    return {st, fl, ret_m};
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
    end
  endtask

  // scoreboard compare, one expected word per cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      act_w = {bus.state, bus.ic_read, bus.ir_ld, bus.pc_incr, bus.pc_ld,
               bus.rf_read, bus.rf_write, bus.dc_read, bus.dc_write,
               bus.wb_sel, bus.halted, bus.illegal, bus.retired};
      chk("cycle", 32'(act_w), 32'(exp_w));
    end
  end

  // driver tasks; each tick starts and ends 1 time unit after a rising edge
  task automatic tick(input logic st, input logic [5:0] op, input logic bq,
                      input logic [W-1:0] e);
    bus.start  = st;
    bus.opcode = op;
    bus.beq_eq = bq;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, rop(), rbit(), w(4'd0, 11'd0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset  = 1'b1;
    ret_m  = 16'd0;
    ill_m  = 1'b0;
    idle_m = 1'b1;
    tick(1'b0, rop(), rbit(), w(4'd0, 11'd0));
    tick(1'b0, rop(), rbit(), w(4'd0, 11'd0));
    reset = 1'b0;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic bq, input int abort_at);
    logic [W-1:0] seq[$];
    logic st_v;
    logic [5:0] op_v;
    logic bq_v;
    logic halts;
    halts = 1'b0;
    seq.push_back(w(4'd1, F_IC));
    seq.push_back(w(4'd2, F_IR | F_PCI));
    seq.push_back(w(4'd3, F_RFR));
    seq.push_back(w(4'd4, 11'd0));
    if (op == LW_OP) begin
      seq.push_back(w(4'd5, F_DCR));
      seq.push_back(w(4'd6, F_RFW | F_WBS));
    end else if (op == SW_OP) begin
      seq.push_back(w(4'd5, F_DCW));
    end else if (op == BEQ_OP) begin
      seq.push_back(w(4'd7, bq ? F_PCL : 11'd0));
    end else if (op inside {6'd1, 6'd2, 6'd3, 6'd4, 6'd7}) begin
      seq.push_back(w(4'd6, F_RFW));
    end else begin
      if (op != HALT_OP) ill_m = 1'b1;
      halts = 1'b1;
      seq.push_back(w(4'd8, F_HLT | (ill_m ? F_ILL : 11'd0)));
    end
    for (int k = 0; k < seq.size(); k++) begin
      st_v = (k == 0 && idle_m) ? 1'b1 : rbit();
      op_v = (k == 3) ? op : rop();
      bq_v = (k == 4) ? bq : rbit();
      tick(st_v, op_v, bq_v, seq[k]);
      if (k == 0) idle_m = 1'b0;
      if (k == abort_at) begin
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_state", 32'(bus.state), 32'd0);
        chk("abort_dc_read", 32'(bus.dc_read), 32'd0);
        chk("abort_retired", 32'(bus.retired), 32'd0);
        ret_m  = 16'd0;
        ill_m  = 1'b0;
        idle_m = 1'b1;
        tick(1'b0, rop(), rbit(), w(4'd0, 11'd0));
        reset = 1'b0;
        return;
      end
    end
    if (halts) begin
      for (int h = 0; h < 5; h++)
        tick(rbit(), rop(), rbit(), w(4'd8, F_HLT | (ill_m ? F_ILL : 11'd0)));
    end else begin
      ret_m = ret_m + 16'd1;
    end
  endtask

  initial begin
    logic [5:0] op;
    n_chk  = 0;
    n_err  = 0;
    ret_m  = 16'd0;
    ill_m  = 1'b0;
    idle_m = 1'b1;
    alu_ops = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd7};
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.opcode = 6'd0;
    bus.beq_eq = 1'b0;

    @(posedge clk);
    #1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_strobes", 32'({bus.ic_read, bus.ir_ld, bus.pc_incr, bus.pc_ld, bus.rf_read,
                            bus.rf_write, bus.dc_read, bus.dc_write, bus.wb_sel}), 32'd0);
    chk("rst_flags", 32'({bus.halted, bus.illegal, bus.retired}), 32'd0);
    tick(1'b0, rop(), rbit(), w(4'd0, 11'd0));
    reset = 1'b0;

    // single ALU instruction, then halt
    idle(3);
    run_instr(6'd1, 1'b0, -1);
    run_instr(HALT_OP, 1'b0, -1);
    chk("alu_retired", 32'(bus.retired), 32'd1);
    chk("halt_flag", 32'(bus.halted), 32'd1);
    chk("halt_no_illegal", 32'(bus.illegal), 32'd0);

    // directed memory/branch mix followed by a random program
    do_reset();
    idle(2);
    run_instr(LW_OP, 1'b0, -1);
    run_instr(SW_OP, 1'b0, -1);
    run_instr(BEQ_OP, 1'b1, -1);
    run_instr(BEQ_OP, 1'b0, -1);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       op = alu_ops[$urandom_range(0, 4)];
        1:       op = LW_OP;
        2:       op = SW_OP;
        default: op = BEQ_OP;
      endcase
      run_instr(op, rbit(), -1);
    end
    run_instr(HALT_OP, 1'b0, -1);
    chk("prog_retired", 32'(bus.retired), 32'd44);

    // unknown opcode
    do_reset();
    idle(1);
    run_instr(6'd9, 1'b0, -1);
    chk("illegal_flag", 32'(bus.illegal), 32'd1);
    chk("illegal_halted", 32'(bus.halted), 32'd1);
    chk("illegal_state", 32'(bus.state), 32'd8);

    // reset during the MEM cycle of a load
    do_reset();
    idle(1);
    run_instr(6'd2, 1'b0, -1);
    run_instr(LW_OP, 1'b0, 4);
    idle(2);
    run_instr(6'd4, 1'b0, -1);
    run_instr(HALT_OP, 1'b0, -1);
    chk("post_abort_retired", 32'(bus.retired), 32'd1);

    // counter wrap
    do_reset();
    idle(1);
    @(negedge clk);
    #1;
    force dut.retired_q = 16'hFFFF;
    ret_m = 16'hFFFF;
    idle(2);
    release dut.retired_q;
    idle(1);
    run_instr(6'd3, 1'b0, -1);
    run_instr(HALT_OP, 1'b0, -1);
    chk("wrap_retired", 32'(bus.retired), 32'd0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
